if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/if_id_stage_pc_reg.sv | 55 +++++
 rtl/if_id_stage.sv | 99 +++++++++
 tb/tb_if_id_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: reset PC, NOP encoding, register field
// positions and small helpers used by the fetch stage and its PC register.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 16;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'h0000_0004;

    // Register-address field positions inside a 32-bit instruction
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;

    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // Next-PC source selection
    typedef enum logic [1:0] {
        PC_SEL_SEQ      = 2'd0,
        PC_SEL_HOLD     = 2'd1,
        PC_SEL_REDIRECT = 2'd2,
        PC_SEL_RESET    = 2'd3
    } pc_sel_e;

    // Extract rs1 from an instruction word
    function automatic logic [REG_ADDR_W-1:0] get_rs1(input logic [XLEN-1:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    // Extract rs2 from an instruction word
    function automatic logic [REG_ADDR_W-1:0] get_rs2(input logic [XLEN-1:0] instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

    // Extract rd from an instruction word
    function automatic logic [REG_ADDR_W-1:0] get_rd(input logic [XLEN-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

    // Saturating increment for the hazard event counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : (value + 16'd1);
    endfunction

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter register with its next-PC mux.
// Priority: reset, then redirect (flush), then hold (stall), else PC+4 (wraps).
module pc_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc
);

    pc_sel_e         pc_sel_s;
    logic [XLEN-1:0] pc_next_s;
    logic [XLEN-1:0] pc_r;

    // Choose the next-PC source; flush outranks stall so a redirect is never lost
    always_comb begin
        pc_sel_s = PC_SEL_SEQ;
        if (rst) begin
            pc_sel_s = PC_SEL_RESET;
        end else if (flush) begin
            pc_sel_s = PC_SEL_REDIRECT;
        end else if (stall) begin
            pc_sel_s = PC_SEL_HOLD;
        end else begin
            pc_sel_s = PC_SEL_SEQ;
        end
    end

    // Next-PC mux; the branch target is taken as-is, low bits included
    always_comb begin
        pc_next_s = pc_r;
        case (pc_sel_s)
            PC_SEL_RESET:    pc_next_s = RESET_PC;
            PC_SEL_REDIRECT: pc_next_s = branch_target;
            PC_SEL_HOLD:     pc_next_s = pc_r;
            PC_SEL_SEQ:      pc_next_s = pc_r + PC_STEP;
            default:         pc_next_s = RESET_PC;
        endcase
    end

    // PC state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/if_id_stage.sv
// IF stage plus IF/ID pipeline register of a 5-stage RV32 core.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush event counters
// (ports stall_count and flush_count exist only when it is defined).
module if_id_stage
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [XLEN-1:0]       branch_target,
    output logic [XLEN-1:0]       imem_addr,
    input  logic [XLEN-1:0]       imem_rdata,
    output logic [XLEN-1:0]       IF_ID_PC,
    output logic [XLEN-1:0]       IF_ID_Instr,
    output logic                  IF_ID_Valid,
    output logic [REG_ADDR_W-1:0] IF_ID_RegRs1,
    output logic [REG_ADDR_W-1:0] IF_ID_RegRs2,
    output logic [REG_ADDR_W-1:0] IF_ID_RegRd
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
`endif
);

    logic [XLEN-1:0] pc_s;
    logic [XLEN-1:0] if_id_pc_r;
    logic [XLEN-1:0] if_id_instr_r;
    logic            if_id_valid_r;

    pc_reg u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .pc            (pc_s)
    );

    // The memory is addressed straight from the PC register
    assign imem_addr = pc_s;

    // IF/ID register: flush inserts a bubble, stall freezes, otherwise capture the fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_pc_r    <= RESET_PC;
            if_id_instr_r <= NOP_INSTR;
            if_id_valid_r <= 1'b0;
        end else if (flush) begin
            if_id_pc_r    <= 32'h0000_0000;
            if_id_instr_r <= NOP_INSTR;
            if_id_valid_r <= 1'b0;
        end else if (stall) begin
            if_id_pc_r    <= if_id_pc_r;
            if_id_instr_r <= if_id_instr_r;
            if_id_valid_r <= if_id_valid_r;
        end else begin
            if_id_pc_r    <= pc_s;
            if_id_instr_r <= imem_rdata;
            if_id_valid_r <= 1'b1;
        end
    end

    assign IF_ID_PC    = if_id_pc_r;
    assign IF_ID_Instr = if_id_instr_r;
    assign IF_ID_Valid = if_id_valid_r;

    // Register fields go to the hazard unit without an extra cycle of delay
    assign IF_ID_RegRs1 = get_rs1(if_id_instr_r);
    assign IF_ID_RegRs2 = get_rs2(if_id_instr_r);
    assign IF_ID_RegRd  = get_rd(if_id_instr_r);

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_count_r;
    logic [CNT_W-1:0] flush_count_r;

    // Saturating event counters; a stall that coincides with a flush counts only as a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= 16'h0000;
            flush_count_r <= 16'h0000;
        end else if (flush) begin
            stall_count_r <= stall_count_r;
            flush_count_r <= sat_inc(flush_count_r);
        end else if (stall) begin
            stall_count_r <= sat_inc(stall_count_r);
            flush_count_r <= flush_count_r;
        end else begin
            stall_count_r <= stall_count_r;
            flush_count_r <= flush_count_r;
        end
    end

    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios followed by random
// stall/flush/reset traffic, compared every cycle against a behavioural model.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;
    logic [4:0]  IF_ID_RegRs1;
    logic [4:0]  IF_ID_RegRs2;
    logic [4:0]  IF_ID_RegRd;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    if_id_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .IF_ID_PC      (IF_ID_PC),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_Valid   (IF_ID_Valid),
        .IF_ID_RegRs1  (IF_ID_RegRs1),
        .IF_ID_RegRs2  (IF_ID_RegRs2),
        .IF_ID_RegRd   (IF_ID_RegRd)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count   (stall_count),
        .flush_count   (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: either one fixed word or a scrambled function of the address
    bit          mem_fixed;
    logic [31:0] mem_fixed_val;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (mem_fixed) return mem_fixed_val;
        else return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    // Behavioural reference state
    logic [31:0] m_pc;
    logic [31:0] m_ifid_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    int unsigned m_stall_cnt;
    int unsigned m_flush_cnt;

    int passed;
    int failed;
    int total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("if_id_pc", IF_ID_PC, m_ifid_pc);
        chk("if_id_instr", IF_ID_Instr, m_instr);
        chk("if_id_valid", {31'd0, IF_ID_Valid}, {31'd0, m_valid});
        chk("rs1", {27'd0, IF_ID_RegRs1}, {27'd0, m_instr[19:15]});
        chk("rs2", {27'd0, IF_ID_RegRs2}, {27'd0, m_instr[24:20]});
        chk("rd", {27'd0, IF_ID_RegRd}, {27'd0, m_instr[11:7]});
`ifdef HAZARD_STATS_EN
        chk("stall_count", {16'd0, stall_count}, m_stall_cnt);
        chk("flush_count", {16'd0, flush_count}, m_flush_cnt);
`endif
    endtask

    // One clock: apply inputs, advance the model by the fetch-stage rules, compare
    task automatic step(input bit r, input bit s, input bit f, input logic [31:0] bt);
        rst           = r;
        stall         = s;
        flush         = f;
        branch_target = bt;
        @(posedge clk);
        if (r) begin
            m_pc        = 32'h0;
            m_ifid_pc   = 32'h0;
            m_instr     = 32'h0000_0013;
            m_valid     = 1'b0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else if (f) begin
            m_pc        = bt;
            m_ifid_pc   = 32'h0;
            m_instr     = 32'h0000_0013;
            m_valid     = 1'b0;
            if (m_flush_cnt < 65535) m_flush_cnt++;
        end else if (s) begin
            if (m_stall_cnt < 65535) m_stall_cnt++;
        end else begin
            m_instr   = mem_word(m_pc);
            m_ifid_pc = m_pc;
            m_valid   = 1'b1;
            m_pc      = m_pc + 32'd4;
        end
        #1;
        check_all();
    endtask

    initial begin
        passed = 0;
        failed = 0;
        total  = 0;
        mem_fixed     = 1'b1;
        mem_fixed_val = 32'h00A0_0093;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = 32'h0;

        // Reset
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("reset_addr", imem_addr, 32'h0);

        // Three free cycles with a fixed addi x1 instruction
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("free1_addr", imem_addr, 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("free3_addr", imem_addr, 32'd12);
        chk("free3_ifid_pc", IF_ID_PC, 32'd8);
        chk("free3_rd", {27'd0, IF_ID_RegRd}, 32'd1);

        // Stall at PC=8 for two cycles, then release
        mem_fixed = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pre_stall_addr", imem_addr, 32'd12);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("stall_addr", imem_addr, 32'd12);
        chk("stall_ifid_pc", IF_ID_PC, 32'd8);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("release_ifid_pc", IF_ID_PC, 32'd12);

        // Flush to 0x100
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        chk("flush_addr", imem_addr, 32'h100);
        chk("flush_instr", IF_ID_Instr, 32'h0000_0013);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("after_flush_pc", IF_ID_PC, 32'h100);

        // Stall and flush together: flush wins
        step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        chk("both_addr", imem_addr, 32'h40);
        chk("both_valid", {31'd0, IF_ID_Valid}, 32'd0);

        // Consecutive flushes, unaligned target, then PC wrap at the top of memory
        step(1'b0, 1'b0, 1'b1, 32'h0000_0203);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of a stall
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rst_mid_stall_valid", {31'd0, IF_ID_Valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          s;
            bit          f;
            logic [31:0] bt;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 25);
            f  = ($urandom_range(0, 99) < 15);
            bt = $urandom();
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 49) == 0) bt = 32'hFFFF_FFF8;
            step(r, s, f, bt);
        end

`ifdef HAZARD_STATS_EN
        // Long stall saturates the counter, then reset mid-stall clears everything
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 70000; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
        end
        chk("stall_sat", {16'd0, stall_count}, 32'h0000_FFFF);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("sat_rst_count", {16'd0, stall_count}, 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
